interval_timer_bank: RTL and testbench
======================================

Name: interval_timer_bank

Overview:
Parametrised successor to the single-set traffic-light time parameter store. Holds NUM_INTERVALS programmable interval durations as shadow/active register pairs, with a guarded commit. Provides a registered lookup of the active duration and an integrated countdown timer with an expiry pulse. Sits between the operator switch/button front end and the light-sequencing FSM.

Parameters:
NUM_INTERVALS, 4, number of interval entries (2..16)
SEL_W, 2, width of entry select/code buses; must satisfy 2**SEL_W >= NUM_INTERVALS
VAL_W, 4, width of each duration value in clk cycles
DEFAULT_VALUES, {4'd9,4'd2,4'd3,4'd6}, packed reset values, NUM_INTERVALS*VAL_W bits, entry 0 in LSBs (base=6, ext=3, yel=2, base+ext=9)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
prog_we  input  1  write prog_value into shadow entry prog_sel
prog_sel  input  SEL_W  shadow entry to write
prog_value  input  VAL_W  value to write
prog_sync  input  1  commit request: copy all shadow entries into active entries
commit_ack  output  1  one-cycle pulse, cycle after active entries updated
interval_code  input  SEL_W  entry used for value lookup and timer load
value  output  VAL_W  registered active[interval_code]
start  input  1  load timer from active[interval_code]
busy  output  1  timer running
count  output  VAL_W  remaining cycles
expired  output  1  one-cycle pulse at end of countdown

Behaviour:
- Reset (async, active-high; clk is the only clock): shadow[i] and active[i] = DEFAULT_VALUES entry i; value=0, count=0, busy=0, expired=0, commit_ack=0, commit_pending=0. Reset asserted mid-countdown aborts the countdown without an expired pulse.
- Shadow write: on clk, if prog_we, prog_sel < NUM_INTERVALS, and prog_value != 0, then shadow[prog_sel] <= prog_value. A zero value or out-of-range select is silently dropped and the shadow entry is unchanged.
- Commit:
  - prog_sync=1 with busy=0: active <= shadow on that edge; commit_ack=1 on the next cycle.
  - prog_sync=1 with busy=1: commit_pending <= 1. The commit executes on the first edge where busy=0, then commit_pending clears and commit_ack pulses on the following cycle. Active values never change during a countdown.
  - prog_sync held high commits again on every eligible edge.
- Simultaneous prog_we and commit: the commit copies the pre-write shadow contents. The new value lands in shadow only.
- Lookup: value <= active[interval_code] every edge, 1-cycle latency. Out-of-range code: value holds its previous value. During a commit edge, the lookup reads the pre-commit active values.
- Timer:
  - IDLE (busy=0): start=1 with in-range interval_code loads count <= active[interval_code] and sets busy=1. start with an out-of-range code is ignored.
  - RUN (busy=1): count decrements by 1 per edge. On the edge where count==1, set count<=0, busy<=0, expired<=1 for exactly one cycle.
  - Duration: busy is high for exactly N cycles for a loaded value N. Zero is unreachable because zero writes are rejected.
  - start while busy, including the expiry edge, is ignored. A new start is accepted on the first edge with busy=0, which is the cycle expired is high.
- Arithmetic is unsigned VAL_W with no wrap: decrement occurs only when count>=1.

Test Plan:
- Reset defaults: assert reset, release, step interval_code 0..3 -> value 6,3,2,9 each 1 cycle after code change; busy=0, expired=0.
- Program/commit: prog_we sel=0 val=8, then sel=2 val=0 -> no active change before prog_sync; pulse prog_sync -> commit_ack next cycle; code0 reads 8, code2 still reads 2.
- Countdown: code=0 (active 6), pulse start -> busy high 6 cycles, count 6,5,4,3,2,1 then 0; expired high exactly 1 cycle; start during busy ignored.
- Deferred commit: start code=2 (value 2), write shadow0=5, prog_sync during busy -> active unchanged while busy; commit on first idle edge; commit_ack one cycle later; code0 then reads 5.
- Simultaneous write+commit: same edge prog_we sel1 val=7 and prog_sync -> active1 keeps the old value; second prog_sync -> active1=7.
- Async reset mid-countdown: reset at count=3 -> busy=0, count=0 immediately; no expired pulse; actives back to defaults.

Source files
------------

// File: rtl/interval_timer_bank.sv
// Bank of programmable interval durations (shadow/active pairs with guarded commit),
// registered active-value lookup and an integrated countdown timer with expiry pulse.
module interval_timer_bank #(
   parameter int NUM_INTERVALS = 4,
   parameter int SEL_W         = 2,
   parameter int VAL_W         = 4,
   parameter logic [NUM_INTERVALS*VAL_W-1:0] DEFAULT_VALUES = {4'd9, 4'd2, 4'd3, 4'd6}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             prog_we,
   input  logic [SEL_W-1:0] prog_sel,
   input  logic [VAL_W-1:0] prog_value,
   input  logic             prog_sync,
   output logic             commit_ack,
   input  logic [SEL_W-1:0] interval_code,
   output logic [VAL_W-1:0] value,
   input  logic             start,
   output logic             busy,
   output logic [VAL_W-1:0] count,
   output logic             expired
);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   localparam logic [SEL_W:0] NUM_ENTRIES = (SEL_W+1)'(NUM_INTERVALS);

   state_t           state_q, state_d;
   logic [VAL_W-1:0] shadow_q [NUM_INTERVALS];
   logic [VAL_W-1:0] shadow_d [NUM_INTERVALS];
   logic [VAL_W-1:0] active_q [NUM_INTERVALS];
   logic [VAL_W-1:0] active_d [NUM_INTERVALS];
   logic [VAL_W-1:0] value_q, value_d;
   logic [VAL_W-1:0] count_q, count_d;
   logic             expired_q, expired_d;
   logic             commit_ack_q, commit_ack_d;
   logic             commit_pending_q, commit_pending_d;

   logic             code_ok;
   logic             sel_ok;
   logic             wr_ok;
   logic             commit_now;
   logic [VAL_W-1:0] active_sel;

   assign code_ok    = {1'b0, interval_code} < NUM_ENTRIES;
   assign sel_ok     = {1'b0, prog_sel} < NUM_ENTRIES;
   assign wr_ok      = prog_we && sel_ok && (prog_value != '0);
   // Commits are held off while counting so the running interval never sees a change.
   assign commit_now = (prog_sync || commit_pending_q) && (state_q == ST_IDLE);

   always_comb begin
      active_sel = '0;
      if (code_ok) begin
         active_sel = active_q[interval_code];
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_INTERVALS; gi++) begin : g_entry
         // Commit copies the pre-write shadow, so a same-edge write lands in shadow only.
         assign shadow_d[gi] = (wr_ok && prog_sel == SEL_W'(gi)) ? prog_value : shadow_q[gi];
         assign active_d[gi] = commit_now ? shadow_q[gi] : active_q[gi];
      end
   endgenerate

   always_comb begin
      commit_pending_d = commit_pending_q;
      if (commit_now) begin
         commit_pending_d = 1'b0;
      end else if (prog_sync) begin
         commit_pending_d = 1'b1;
      end
   end

   assign commit_ack_d = commit_now;
   assign value_d      = code_ok ? active_sel : value_q;

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      expired_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && code_ok) begin
               state_d = ST_RUN;
               count_d = active_sel;
            end
         end
         ST_RUN: begin
            if (count_q <= VAL_W'(1)) begin
               state_d   = ST_IDLE;
               count_d   = '0;
               expired_d = 1'b1;
            end else begin
               count_d = count_q - VAL_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            count_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_INTERVALS; i++) begin
            shadow_q[i] <= DEFAULT_VALUES[i*VAL_W +: VAL_W];
            active_q[i] <= DEFAULT_VALUES[i*VAL_W +: VAL_W];
         end
         state_q          <= ST_IDLE;
         value_q          <= '0;
         count_q          <= '0;
         expired_q        <= 1'b0;
         commit_ack_q     <= 1'b0;
         commit_pending_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_INTERVALS; i++) begin
            shadow_q[i] <= shadow_d[i];
            active_q[i] <= active_d[i];
         end
         state_q          <= state_d;
         value_q          <= value_d;
         count_q          <= count_d;
         expired_q        <= expired_d;
         commit_ack_q     <= commit_ack_d;
         commit_pending_q <= commit_pending_d;
      end
   end

   assign busy       = (state_q == ST_RUN);
   assign count      = count_q;
   assign expired    = expired_q;
   assign commit_ack = commit_ack_q;
   assign value      = value_q;

endmodule

// File: tb/tb_interval_timer_bank.sv
// Self-checking bench for interval_timer_bank: directed scenarios plus randomized
// traffic compared against a behavioural model of the interval bank and timer.
module tb_interval_timer_bank;

   logic       clk;
   logic       reset;
   logic       prog_we;
   logic [1:0] prog_sel;
   logic [3:0] prog_value;
   logic       prog_sync;
   logic       commit_ack;
   logic [1:0] interval_code;
   logic [3:0] value;
   logic       start;
   logic       busy;
   logic [3:0] count;
   logic       expired;

   int n_checks = 0;
   int n_fails  = 0;

   interval_timer_bank dut (
      .clk          (clk),
      .reset        (reset),
      .prog_we      (prog_we),
      .prog_sel     (prog_sel),
      .prog_value   (prog_value),
      .prog_sync    (prog_sync),
      .commit_ack   (commit_ack),
      .interval_code(interval_code),
      .value        (value),
      .start        (start),
      .busy         (busy),
      .count        (count),
      .expired      (expired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: durations as plain integers, timer as "cycles remaining".
   int dflt [4] = '{6, 3, 2, 9};
   int m_shadow [4];
   int m_active [4];
   int m_value;
   int m_remaining;
   bit m_expired;
   bit m_ack;
   bit m_pending;

   wire m_idle      = (m_remaining == 0);
   wire m_do_commit = (prog_sync || m_pending) && m_idle;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            m_shadow[i] <= dflt[i];
            m_active[i] <= dflt[i];
         end
         m_value     <= 0;
         m_remaining <= 0;
         m_expired   <= 1'b0;
         m_ack       <= 1'b0;
         m_pending   <= 1'b0;
      end else begin
         m_value   <= m_active[interval_code];
         m_expired <= (m_remaining == 1);
         if (!m_idle)
            m_remaining <= m_remaining - 1;
         else if (start)
            m_remaining <= m_active[interval_code];
         m_ack <= m_do_commit;
         if (m_do_commit) begin
            m_pending <= 1'b0;
            for (int i = 0; i < 4; i++) m_active[i] <= m_shadow[i];
         end else if (prog_sync) begin
            m_pending <= 1'b1;
         end
         if (prog_we && prog_value != 0)
            m_shadow[prog_sel] <= int'(prog_value);
      end
   end

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic idle_inputs();
      prog_we = 0; prog_sel = 0; prog_value = 0; prog_sync = 0; start = 0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      step(1);
   endtask

   task automatic test_reset();
      int exp_v [4] = '{6, 3, 2, 9};
      apply_reset();
      n_checks++;
      if (busy !== 1'b0 || expired !== 1'b0 || count !== 4'd0 || commit_ack !== 1'b0) begin
         n_fails++;
         $display("FAIL reset_outputs: busy=%0b expired=%0b count=%0d ack=%0b, required 0/0/0/0",
                  busy, expired, count, commit_ack);
      end
      for (int c = 0; c < 4; c++) begin
         interval_code = 2'(c);
         step(1);
         n_checks++;
         if (value !== 4'(exp_v[c])) begin
            n_fails++;
            $display("FAIL reset_value code%0d: got %0d, required %0d", c, value, exp_v[c]);
         end
         $display("reset lookup code=%0d value=%0d", c, value);
      end
   endtask

   task automatic test_program_commit();
      prog_we = 1; prog_sel = 0; prog_value = 8;
      step(1);
      prog_sel = 2; prog_value = 0;
      step(1);
      prog_we = 0; interval_code = 0;
      step(1);
      n_checks++;
      if (value !== 4'd6) begin
         n_fails++;
         $display("FAIL precommit_code0: got %0d, required 6", value);
      end
      prog_sync = 1;
      step(1);
      prog_sync = 0;
      n_checks++;
      if (commit_ack !== 1'b1) begin
         n_fails++;
         $display("FAIL commit_ack_pulse: got %0b, required 1", commit_ack);
      end
      step(1);
      n_checks++;
      if (commit_ack !== 1'b0 || value !== 4'd8) begin
         n_fails++;
         $display("FAIL commit_code0: ack=%0b value=%0d, required ack=0 value=8", commit_ack, value);
      end
      interval_code = 2;
      step(1);
      n_checks++;
      if (value !== 4'd2) begin
         n_fails++;
         $display("FAIL zero_write_dropped code2: got %0d, required 2", value);
      end
      $display("program/commit done code0=8 code2=%0d", value);
   endtask

   task automatic test_countdown();
      apply_reset();
      interval_code = 0; start = 1;
      step(1);
      start = 0;
      n_checks++;
      if (busy !== 1'b1 || count !== 4'd6 || expired !== 1'b0) begin
         n_fails++;
         $display("FAIL countdown_load: busy=%0b count=%0d expired=%0b, required 1/6/0", busy, count, expired);
      end
      for (int k = 5; k >= 1; k--) begin
         if (k == 4) begin start = 1; interval_code = 3; end
         step(1);
         start = 0;
         n_checks++;
         if (busy !== 1'b1 || count !== 4'(k) || expired !== 1'b0) begin
            n_fails++;
            $display("FAIL countdown_run k=%0d: busy=%0b count=%0d expired=%0b, required 1/%0d/0",
                     k, busy, count, expired, k);
         end
      end
      step(1);
      n_checks++;
      if (busy !== 1'b0 || count !== 4'd0 || expired !== 1'b1) begin
         n_fails++;
         $display("FAIL countdown_expire: busy=%0b count=%0d expired=%0b, required 0/0/1", busy, count, expired);
      end
      step(1);
      n_checks++;
      if (expired !== 1'b0 || busy !== 1'b0) begin
         n_fails++;
         $display("FAIL expired_one_cycle: expired=%0b busy=%0b, required 0/0", expired, busy);
      end
      $display("countdown of 6 cycles complete");
   endtask

   task automatic test_deferred_commit();
      interval_code = 2; start = 1;
      step(1);
      start = 0;
      n_checks++;
      if (busy !== 1'b1 || count !== 4'd2) begin
         n_fails++;
         $display("FAIL deferred_load: busy=%0b count=%0d, required 1/2", busy, count);
      end
      prog_we = 1; prog_sel = 0; prog_value = 5; prog_sync = 1;
      step(1);
      idle_inputs();
      interval_code = 0;
      n_checks++;
      if (busy !== 1'b1 || count !== 4'd1 || commit_ack !== 1'b0) begin
         n_fails++;
         $display("FAIL deferred_hold: busy=%0b count=%0d ack=%0b, required 1/1/0", busy, count, commit_ack);
      end
      step(1);
      n_checks++;
      if (busy !== 1'b0 || expired !== 1'b1 || commit_ack !== 1'b0 || value !== 4'd6) begin
         n_fails++;
         $display("FAIL deferred_expire: busy=%0b exp=%0b ack=%0b value=%0d, required 0/1/0/6",
                  busy, expired, commit_ack, value);
      end
      step(1);
      n_checks++;
      if (commit_ack !== 1'b1 || value !== 4'd6) begin
         n_fails++;
         $display("FAIL deferred_ack: ack=%0b value=%0d, required 1/6", commit_ack, value);
      end
      step(1);
      n_checks++;
      if (commit_ack !== 1'b0 || value !== 4'd5) begin
         n_fails++;
         $display("FAIL deferred_value: ack=%0b value=%0d, required 0/5", commit_ack, value);
      end
      $display("deferred commit done code0=%0d", value);
   endtask

   task automatic test_simul_write_commit();
      prog_we = 1; prog_sel = 1; prog_value = 7; prog_sync = 1;
      step(1);
      idle_inputs();
      interval_code = 1;
      n_checks++;
      if (commit_ack !== 1'b1) begin
         n_fails++;
         $display("FAIL simul_ack: got %0b, required 1", commit_ack);
      end
      step(1);
      n_checks++;
      if (value !== 4'd3) begin
         n_fails++;
         $display("FAIL simul_old_active1: got %0d, required 3", value);
      end
      prog_sync = 1;
      step(1);
      prog_sync = 0;
      step(1);
      n_checks++;
      if (value !== 4'd7) begin
         n_fails++;
         $display("FAIL simul_second_commit active1: got %0d, required 7", value);
      end
      $display("simultaneous write+commit done code1=%0d", value);
   endtask

   task automatic test_reset_mid_countdown();
      interval_code = 3; start = 1;
      step(1);
      start = 0;
      step(6);
      n_checks++;
      if (busy !== 1'b1 || count !== 4'd3) begin
         n_fails++;
         $display("FAIL midreset_setup: busy=%0b count=%0d, required 1/3", busy, count);
      end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (busy !== 1'b0 || count !== 4'd0 || expired !== 1'b0) begin
         n_fails++;
         $display("FAIL midreset_async: busy=%0b count=%0d expired=%0b, required 0/0/0", busy, count, expired);
      end
      step(3);
      n_checks++;
      if (expired !== 1'b0 || busy !== 1'b0) begin
         n_fails++;
         $display("FAIL midreset_no_expire: expired=%0b busy=%0b, required 0/0", expired, busy);
      end
      reset = 1'b0;
      interval_code = 1;
      step(1);
      n_checks++;
      if (value !== 4'd3) begin
         n_fails++;
         $display("FAIL midreset_defaults code1: got %0d, required 3", value);
      end
      $display("reset mid-countdown done");
   endtask

   task automatic test_random();
      for (int t = 0; t < 400; t++) begin
         prog_we       = ($urandom_range(0, 3) == 0);
         prog_sel      = 2'($urandom_range(0, 3));
         prog_value    = 4'($urandom_range(0, 15));
         prog_sync     = ($urandom_range(0, 9) == 0);
         start         = ($urandom_range(0, 3) == 0);
         interval_code = 2'($urandom_range(0, 3));
         step(1);
         n_checks++;
         if (value !== 4'(m_value) || busy !== (m_remaining != 0) || count !== 4'(m_remaining)
             || expired !== m_expired || commit_ack !== m_ack) begin
            n_fails++;
            $display("FAIL random t=%0d: value=%0d busy=%0b count=%0d exp=%0b ack=%0b, required %0d/%0b/%0d/%0b/%0b",
                     t, value, busy, count, expired, commit_ack,
                     m_value, (m_remaining != 0), m_remaining, m_expired, m_ack);
         end
         $display("random t=%0d we=%0b sel=%0d val=%0d sync=%0b start=%0b code=%0d -> value=%0d count=%0d",
                  t, prog_we, prog_sel, prog_value, prog_sync, start, interval_code, value, count);
      end
      idle_inputs();
   endtask

   initial begin
      reset = 1'b1;
      interval_code = 0;
      idle_inputs();
      test_reset();
      test_program_commit();
      test_countdown();
      test_deferred_commit();
      test_simul_write_commit();
      test_reset_mid_countdown();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
